// File: rtl/usb_pkg.sv
// Shared encodings for the USB receive frame parser: FSM states, sync bytes, error causes.
package usb_pkg;

    typedef enum logic [2:0] {
        HUNT0,
        HUNT1,
        CMD,
        LEN,
        PAYLOAD,
        CHK
    } state_t;

    localparam logic [7:0] SYNC0 = 8'h55;
    localparam logic [7:0] SYNC1 = 8'hAA;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_CHK  = 2'd1,
        ERR_LEN  = 2'd2,
        ERR_TMO  = 2'd3
    } err_t;

endpackage

// File: rtl/usb_rx_frame_parser.sv
// Parses 55 AA CMD LEN payload CHK frames from the USB RX FIFO into a payload stream.
// Optional inter-byte timeout enabled by defining USB_RX_PARSER_TIMEOUT_EN.
module usb_rx_frame_parser
    import usb_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 64,
    parameter int unsigned TIMEOUT_CYC = 60000
) (
    input  logic       usb_clk_60m,
    input  logic       sys_rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] cmd_code,
    output logic [7:0] pay_data,
    output logic       pay_valid,
    output logic       pay_last,
    input  logic       pay_ready,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int unsigned CNT_W     = $clog2(MAX_LEN + 1);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         csum;
    logic               acc;
    logic               len_err;
    logic               chk_bad;
    logic               done_pend;
    logic               pend_err;
    logic               tmo_fire;

    assign rx_ready = (state == PAYLOAD) ? (~pay_valid | pay_ready) : 1'b1;
    assign acc      = rx_valid & rx_ready;
    assign len_err  = (state == LEN) && (rx_data > MAX_LEN_B);
    assign chk_bad  = (rx_data != csum);

`ifdef USB_RX_PARSER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge usb_clk_60m or negedge sys_rst_n) begin
        if (!sys_rst_n)
            tmo_cnt <= '0;
        else if (state == HUNT0 || acc || tmo_fire)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_fire = (state != HUNT0) && !acc && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_fire = 1'b0;
`endif

    always_ff @(posedge usb_clk_60m or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state <= HUNT0;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (acc) begin
            case (state)
                HUNT0:   if (rx_data == SYNC0) state_nxt = HUNT1;
                HUNT1: begin
                    if (rx_data == SYNC1)      state_nxt = CMD;
                    else if (rx_data != SYNC0) state_nxt = HUNT0;
                end
                CMD:     state_nxt = LEN;
                LEN: begin
                    if (len_err)              state_nxt = HUNT0;
                    else if (rx_data == 8'd0) state_nxt = CHK;
                    else                      state_nxt = PAYLOAD;
                end
                PAYLOAD: if (cnt == CNT_W'(1)) state_nxt = CHK;
                CHK:     state_nxt = HUNT0;
                default: state_nxt = HUNT0;
            endcase
        end
        if (tmo_fire)
            state_nxt = HUNT0;
    end

    always_ff @(posedge usb_clk_60m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt        <= '0;
            csum       <= '0;
            cmd_code   <= '0;
            pay_data   <= '0;
            pay_valid  <= 1'b0;
            pay_last   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= ERR_NONE;
            done_pend  <= 1'b0;
            pend_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (pay_valid && pay_ready) begin
                pay_valid <= 1'b0;
                pay_last  <= 1'b0;
            end
            // A checksum that arrived while the last payload byte was stalled reports here.
            if (done_pend && pay_valid && pay_ready) begin
                frame_done <= 1'b1;
                frame_err  <= pend_err;
                err_code   <= pend_err ? ERR_CHK : ERR_NONE;
                done_pend  <= 1'b0;
            end
            if (acc) begin
                case (state)
                    CMD: begin
                        cmd_code <= rx_data;
                        csum     <= rx_data;
                    end
                    LEN: begin
                        csum <= csum ^ rx_data;
                        cnt  <= rx_data[CNT_W-1:0];
                        if (len_err) begin
                            frame_done <= 1'b1;
                            frame_err  <= 1'b1;
                            err_code   <= ERR_LEN;
                        end
                    end
                    PAYLOAD: begin
                        pay_data  <= rx_data;
                        pay_valid <= 1'b1;
                        pay_last  <= (cnt == CNT_W'(1));
                        cnt       <= cnt - 1'b1;
                        csum      <= csum ^ rx_data;
                    end
                    CHK: begin
                        if (!pay_valid || pay_ready) begin
                            frame_done <= 1'b1;
                            frame_err  <= chk_bad;
                            err_code   <= chk_bad ? ERR_CHK : ERR_NONE;
                        end else begin
                            done_pend <= 1'b1;
                            pend_err  <= chk_bad;
                        end
                    end
                    default: ;
                endcase
            end
            if (tmo_fire) begin
                frame_done <= 1'b1;
                frame_err  <= 1'b1;
                err_code   <= ERR_TMO;
                pay_valid  <= 1'b0;
                pay_last   <= 1'b0;
                done_pend  <= 1'b0;
            end
        end
    end

endmodule
